// File: rtl/beam_trigger_collector.sv
// Beam trigger collector: gathers qualified per-beam triggers into windowed event
// records with ready/valid handoff and post-event dead time, plus per-beam gated scalers.
module beam_trigger_collector #(
    parameter int NBEAMS  = 2,
    parameter int WINDOW  = 4,
    parameter int HOLDOFF = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NBEAMS-1:0]      trig_i,
    input  logic [NBEAMS-1:0]      mask_i,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [NBEAMS-1:0]      evt_mask_o,
    output logic [15:0]            evt_time_o,
    output logic                   busy_o,
    input  logic                   scal_gate_i,
    output logic                   scal_valid_o,
    output logic [NBEAMS*16-1:0]   scal_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF);

    logic [NBEAMS-1:0]    qual;
    logic [1:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NBEAMS-1:0]    acc_q, acc_d;
    logic [15:0]          time_q, time_d;
    logic [15:0]          ts_q, ts_d;
    logic [NBEAMS*16-1:0] scnt_q, scnt_d;
    logic [NBEAMS*16-1:0] snap_q, snap_d;
    logic                 sval_q, sval_d;
    logic [15:0]          inc;

    assign qual = trig_i & ~mask_i;
    assign ts_d = ts_q + 16'd1;

    // cnt_q counts window cycles in COLLECT and dead-time cycles in HOLDOFF
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        time_d  = time_q;
        case (state_q)
            ST_IDLE: begin
                if (|qual) begin
                    acc_d   = qual;
                    time_d  = ts_q;
                    cnt_d   = 8'd1;
                    state_d = (WINDOW == 1) ? ST_PRESENT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                acc_d = acc_q | qual;
                if (cnt_q == WIN_LAST) begin
                    state_d = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PRESENT: begin
                if (evt_ready_i) begin
                    cnt_d   = 8'd1;
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The snapshot takes the gate cycle's saturated increment; counters then restart at 0.
    always_comb begin
        scnt_d = scnt_q;
        snap_d = snap_q;
        sval_d = scal_gate_i;
        inc    = '0;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
            inc = scnt_q[16*b +: 16];
            if (qual[b] && (inc != 16'hFFFF)) begin
                inc = inc + 16'd1;
            end
            scnt_d[16*b +: 16] = scal_gate_i ? 16'd0 : inc;
            if (scal_gate_i) begin
                snap_d[16*b +: 16] = inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            time_q  <= '0;
            ts_q    <= '0;
            scnt_q  <= '0;
            snap_q  <= '0;
            sval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            time_q  <= time_d;
            ts_q    <= ts_d;
            scnt_q  <= scnt_d;
            snap_q  <= snap_d;
            sval_q  <= sval_d;
        end
    end

    assign evt_valid_o  = (state_q == ST_PRESENT);
    assign busy_o       = (state_q != ST_IDLE);
    assign evt_mask_o   = acc_q;
    assign evt_time_o   = time_q;
    assign scal_valid_o = sval_q;
    assign scal_o       = snap_q;

endmodule

// File: tb/tb_beam_trigger_collector.sv
// Directed self-checking bench for beam_trigger_collector (NBEAMS=2, WINDOW=4, HOLDOFF=8).
module tb_beam_trigger_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  trig;
    logic [1:0]  msk;
    logic        ready;
    logic        gate;
    logic        evt_valid;
    logic [1:0]  evt_mask;
    logic [15:0] evt_time;
    logic        busy;
    logic        scal_valid;
    logic [31:0] scal;

    int checks = 0;
    int errors = 0;
    int tb_ts  = 0;

    always #5 clk = ~clk;

    beam_trigger_collector #(.NBEAMS(2), .WINDOW(4), .HOLDOFF(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .trig_i       (trig),
        .mask_i       (msk),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (ready),
        .evt_mask_o   (evt_mask),
        .evt_time_o   (evt_time),
        .busy_o       (busy),
        .scal_gate_i  (gate),
        .scal_valid_o (scal_valid),
        .scal_o       (scal)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    task automatic wait_idle;
        int n;
        trig  = 2'b00;
        gate  = 1'b0;
        ready = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy=%0b want 0", busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; trig = '0; msk = '0; ready = 1'b0; gate = 1'b0;
        repeat (3) tick();
        checks++;
        if ({evt_valid, busy, scal_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got %b want 000", {evt_valid, busy, scal_valid});
        end
        checks++;
        if ({evt_mask, evt_time, scal} !== 50'd0) begin
            errors++;
            $display("FAIL rst_data mask=%h time=%h scal=%h want 0", evt_mask, evt_time, scal);
        end
        rst_n = 1'b1;
        tb_ts = 0;
    endtask

    task automatic test_single_event;
        int t0;
        wait_idle();
        ready = 1'b1;
        t0 = tb_ts;
        trig = 2'b01;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL se_idle busy=%0b want 0", busy); end
        tick(); trig = 2'b00;
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL se_t1 valid=%0b want 0", evt_valid); end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL se_t2 valid=%0b want 0", evt_valid); end
        tick(); trig = 2'b10;
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL se_t3 valid=%0b want 0", evt_valid); end
        tick(); trig = 2'b00;
        checks++;
        if (evt_valid !== 1'b1 || evt_mask !== 2'b11 || evt_time !== 16'(t0)) begin
            errors++;
            $display("FAIL se_t4 valid=%0b mask=%b time=%0d want 1 11 %0d", evt_valid, evt_mask, evt_time, t0);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL se_t5 valid=%0b busy=%0b want 0 1", evt_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int t0;
        int t1;
        wait_idle();
        ready = 1'b0;
        trig  = 2'b11;
        t0 = tb_ts;
        repeat (4) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_mask !== 2'b11 || evt_time !== 16'(t0)) begin
            errors++;
            $display("FAIL bp_first valid=%0b mask=%b time=%0d want 1 11 %0d", evt_valid, evt_mask, evt_time, t0);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_mask !== 2'b11 || evt_time !== 16'(t0)) begin
                errors++;
                $display("FAIL bp_hold%0d valid=%0b mask=%b time=%0d want 1 11 %0d", i, evt_valid, evt_mask, evt_time, t0);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_h1 valid=%0b want 0", evt_valid); end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (busy !== 1'b1 || evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_holdoff%0d busy=%0b valid=%0b want 1 0", i, busy, evt_valid);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_h9 busy=%0b want 0", busy); end
        t1 = tb_ts;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_h10 busy=%0b want 1", busy); end
        trig = 2'b00;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_time !== 16'(t1) || evt_mask !== 2'b11) begin
            errors++;
            $display("FAIL bp_next valid=%0b mask=%b time=%0d want 1 11 %0d", evt_valid, evt_mask, evt_time, t1);
        end
        wait_idle();
    endtask

    task automatic test_masking;
        int seen;
        gate = 1'b1; trig = 2'b00;
        tick();
        gate = 1'b0; msk = 2'b10; trig = 2'b10;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy || evt_valid) seen = 1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mask_noevt seen=%0d want 0", seen); end
        trig = 2'b00; gate = 1'b1;
        tick();
        gate = 1'b0;
        checks++;
        if (scal_valid !== 1'b1 || scal !== 32'd0) begin
            errors++;
            $display("FAIL mask_scal valid=%0b scal=%h want 1 00000000", scal_valid, scal);
        end
        ready = 1'b1; trig = 2'b01;
        repeat (5) tick();
        trig = 2'b00; gate = 1'b1;
        tick();
        gate = 1'b0;
        checks++;
        if (scal !== 32'h0000_0005) begin
            errors++;
            $display("FAIL mask_beam0 scal=%h want 00000005", scal);
        end
        msk = 2'b00;
        wait_idle();
    endtask

    task automatic test_saturation;
        gate = 1'b1; trig = 2'b00;
        tick();
        gate = 1'b0; ready = 1'b1; trig = 2'b01;
        repeat (70000) tick();
        trig = 2'b00; gate = 1'b1;
        tick();
        gate = 1'b0;
        checks++;
        if (scal_valid !== 1'b1 || scal !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL sat_snap valid=%0b scal=%h want 1 0000ffff", scal_valid, scal);
        end
        tick();
        checks++;
        if (scal_valid !== 1'b0 || scal !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL sat_hold valid=%0b scal=%h want 0 0000ffff", scal_valid, scal);
        end
        trig = 2'b01;
        repeat (3) tick();
        trig = 2'b00; gate = 1'b1;
        tick();
        gate = 1'b0;
        checks++;
        if (scal !== 32'h0000_0003) begin
            errors++;
            $display("FAIL sat_restart scal=%h want 00000003", scal);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back;
        gate = 1'b1; trig = 2'b00;
        tick();
        checks++;
        if (scal_valid !== 1'b1) begin errors++; $display("FAIL b2b_first valid=%0b want 1", scal_valid); end
        trig = 2'b01;
        tick();
        checks++;
        if (scal_valid !== 1'b1 || scal !== 32'h0000_0001) begin
            errors++;
            $display("FAIL b2b_coinc valid=%0b scal=%h want 1 00000001", scal_valid, scal);
        end
        gate = 1'b0; trig = 2'b00;
        tick();
        checks++;
        if (scal_valid !== 1'b0) begin errors++; $display("FAIL b2b_strobe valid=%0b want 0", scal_valid); end
        gate = 1'b1;
        tick();
        gate = 1'b0;
        checks++;
        if (scal_valid !== 1'b1 || scal !== 32'd0) begin
            errors++;
            $display("FAIL b2b_zero valid=%0b scal=%h want 1 00000000", scal_valid, scal);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid;
        int seen;
        ready = 1'b0; trig = 2'b01; gate = 1'b1;
        tick();
        trig = 2'b00; gate = 1'b0;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1 || scal !== 32'h0000_0001) begin
            errors++;
            $display("FAIL rm_pre valid=%0b scal=%h want 1 00000001", evt_valid, scal);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({evt_valid, busy, scal_valid} !== 3'b000 || {evt_mask, evt_time, scal} !== 50'd0) begin
            errors++;
            $display("FAIL rm_async valid=%0b busy=%0b sv=%0b mask=%b time=%h scal=%h want all 0",
                     evt_valid, busy, scal_valid, evt_mask, evt_time, scal);
        end
        tick();
        rst_n = 1'b1;
        tb_ts = 0;
        seen = 0;
        repeat (3) begin
            if (busy || evt_valid) seen = 1;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rm_stale seen=%0d want 0", seen); end
        ready = 1'b1; trig = 2'b01;
        tick();
        trig = 2'b00;
        repeat (3) tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_time !== 16'd3 || evt_mask !== 2'b01) begin
            errors++;
            $display("FAIL rm_ts valid=%0b mask=%b time=%0d want 1 01 3", evt_valid, evt_mask, evt_time);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_backpressure();
        test_masking();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
